ahb_slave_ctrl_p: RTL and testbench
===================================

Name: ahb_slave_ctrl_p

Overview:
Parametrised AHB-Lite slave control FSM that generalises the fixed 7-bit, single-cycle state controller.
- Adds true address/data-phase pipelining, wait states while the USB side holds the buffer, and the two-cycle AHB ERROR response.
- Adds a configurable buffer/register map.
- Sits between the AHB bus and the data buffer / status-control register file of the USB endpoint.
- Produces only control strobes; no data path.

Parameters:
ADDR_W, 7, haddr width.
BUF_BYTES, 64, data-buffer size in bytes; power of two; buffer occupies addresses 0..BUF_BYTES-1.
REG_COUNT, 9, byte registers at BUF_BYTES..BUF_BYTES+REG_COUNT-1.
RO_COUNT, 8, first RO_COUNT registers are read-only.
MAX_SIZE, 2, largest legal hsize (log2 bytes).

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  ADDR_W  address-phase address
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hsize  in  2  log2 transfer bytes
hwrite  in  1  1 = write
bufBusy  in  1  USB side owns buffer; buffer accesses must wait
bufRelease  in  1  one-cycle pulse clearing bufferReserved
state  out  3  0 IDLE, 1 WRITE, 2 READ, 3 WAIT, 4 ERR1, 5 ERR2
storeTxData  out  1  buffer write strobe
getRxData  out  1  buffer read strobe
regWrite  out  1  register write strobe
regRead  out  1  register read strobe
accAddr  out  ADDR_W  latched transfer address
dataSize  out  2  latched hsize
hready  out  1  AHB HREADYOUT
hresp  out  1  AHB HRESP, 1 = ERROR
bufferReserved  out  1  buffer holds AHB-written data

Behaviour:
- Reset: asynchronous, active low, sets state=IDLE, all strobes 0, hresp=0, hready=1, accAddr=0, dataSize=0, bufferReserved=0. Reset mid-transfer aborts it with no strobe.
- Accept: an address phase is accepted on a rising edge when hsel=1, htrans[1]=1 and hready=1. On acceptance, haddr and hsize are latched into accAddr and dataSize.
- BUSY, IDLE or hsel=0 in the address phase: next state IDLE, no strobes.
- Error checks on an accepted transfer, any of:
  - hsize>MAX_SIZE;
  - misaligned: haddr mod 2^hsize != 0;
  - buffer access crossing BUF_BYTES;
  - address >= BUF_BYTES+REG_COUNT;
  - write to a read-only register;
  - register access with hsize!=0.
- Error response: next state ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then IDLE. No strobes. An address phase presented during ERR2 is ignored.
- Legal buffer access, bufBusy=0: next state WRITE or READ with hready=1 and storeTxData or getRxData asserted for exactly that cycle.
- Legal buffer access, bufBusy=1: next state WAIT with hready=0 and no strobe. WAIT holds until a cycle in which bufBusy=0; the following cycle is WRITE or READ with the strobe.
- Legal register access: next state WRITE or READ with regWrite or regRead for one cycle; never waits.
- Pipelining: in a WRITE or READ cycle with hready=1 a new address phase may be accepted. Back-to-back transfers give consecutive strobe cycles with zero gap.
- Latency: address phase at edge k gives the strobe in cycle k+1, or the first cycle after WAIT exits.
- bufferReserved: set on the cycle storeTxData=1; cleared on bufRelease=1. If both occur in the same cycle, set wins.
- dataSize and accAddr hold their value until the next accepted transfer.

Optional Feature:
SEQ_CHECK_EN
- Defined: a SEQ transfer is an error (ERR1/ERR2) when any of these hold:
  - haddr != previous accAddr + 2^dataSize;
  - hsize differs from the previous transfer;
  - the previous transfer was not accepted and legal.
- Not defined: SEQ is treated exactly as NONSEQ.

Test Plan:
- Reset with nRst low for 2 cycles -> state=0, hready=1, hresp=0, bufferReserved=0, all strobes 0.
- NONSEQ write haddr=0x00, hsize=2, bufBusy=0 -> next cycle state=1, storeTxData=1, dataSize=2, bufferReserved=1. A bufRelease pulse later -> bufferReserved=0.
- Back-to-back NONSEQ reads 0x20, 0x24 (hsize=2) -> two consecutive getRxData cycles, accAddr 0x20 then 0x24.
- Write 0x10 with bufBusy=1 for 3 cycles -> WAIT with hready=0 for 3 cycles, then one storeTxData cycle. Read 0x41 -> regRead=1, no getRxData.
- Write 0x43, write 0x15 with hsize=3, write 0x3E with hsize=2 -> each gives ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then IDLE, with no strobes.
- With SEQ_CHECK_EN: NONSEQ 0x00 then SEQ 0x04 (hsize=2) -> legal. SEQ 0x0C -> ERR1/ERR2. Without the macro, the same SEQ 0x0C -> legal write.

Source files
------------

// File: rtl/ahb_slave_ctrl_p.sv
// ahb_slave_ctrl_p: AHB-Lite slave control FSM for a USB endpoint.
// Decodes each accepted address phase against the buffer/register map and
// produces one-cycle buffer or register strobes in the following data phase,
// inserts wait states while the USB side owns the buffer, and answers illegal
// transfers with the two-cycle ERROR response. Control strobes only, no data.
// Optional feature: define SEQ_CHECK_EN to reject SEQ transfers that do not
// continue the previous legal transfer (same size, address advanced by size).
module ahb_slave_ctrl_p #(
    parameter int ADDR_W    = 7,
    parameter int BUF_BYTES = 64,
    parameter int REG_COUNT = 9,
    parameter int RO_COUNT  = 8,
    parameter int MAX_SIZE  = 2
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic [1:0]        hsize,
    input  logic              hwrite,
    input  logic              bufBusy,
    input  logic              bufRelease,
    output logic [2:0]        state,
    output logic              storeTxData,
    output logic              getRxData,
    output logic              regWrite,
    output logic              regRead,
    output logic [ADDR_W-1:0] accAddr,
    output logic [1:0]        dataSize,
    output logic              hready,
    output logic              hresp,
    output logic              bufferReserved
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_ERR1  = 3'd4,
        S_ERR2  = 3'd5
    } state_t;

    // One extra bit so address + size never wraps during the range checks.
    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] BUF_END = AW1'(BUF_BYTES);
    localparam logic [AW1-1:0] RO_END  = AW1'(BUF_BYTES + RO_COUNT);
    localparam logic [AW1-1:0] MAP_END = AW1'(BUF_BYTES + REG_COUNT);

    state_t state_q, state_d;
    logic   pend_write_q;   // direction of the transfer being served
    logic   pend_reg_q;     // transfer targets the register file
    logic   pend_reg_d;
    logic   reserved_q;

    logic [3:0]        size_bytes;
    logic [ADDR_W-1:0] size_mask;
    logic [AW1-1:0]    addr_ext, addr_end;
    logic              is_buf, is_reg, xfer_err, seq_err, accept;

    // Decode the current address phase against the map and the legality rules.
    always_comb begin
        size_bytes = 4'd1 << hsize;
        size_mask  = ADDR_W'(size_bytes - 4'd1);
        addr_ext   = {1'b0, haddr};
        addr_end   = addr_ext + AW1'(size_bytes);
        is_buf     = addr_ext < BUF_END;
        is_reg     = !is_buf && (addr_ext < MAP_END);
        xfer_err   = (hsize > 2'(MAX_SIZE))
                   | (|(haddr & size_mask))
                   | (is_buf && (addr_end > BUF_END))
                   | (addr_ext >= MAP_END)
                   | (is_reg && hwrite && (addr_ext < RO_END))
                   | (is_reg && (hsize != 2'd0))
                   | seq_err;
    end

`ifdef SEQ_CHECK_EN
    logic           last_ok_q;   // previous address phase was accepted and legal
    logic [AW1-1:0] seq_next;

    // A SEQ beat must continue the previous legal transfer with the same size.
    always_comb begin
        seq_next = {1'b0, accAddr} + AW1'(4'd1 << dataSize);
        seq_err  = (htrans == 2'b11) &&
                   ((addr_ext != seq_next) || (hsize != dataSize) || !last_ok_q);
    end

    // Remember whether the last address phase started a legal transfer.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            last_ok_q <= 1'b0;
        else if (accept)
            last_ok_q <= !xfer_err;
        else if (hready && (!hsel || htrans == 2'b00))
            last_ok_q <= 1'b0;
    end
`else
    assign seq_err = 1'b0;
`endif

    // Address phase is taken whenever the bus is ready, except in ERR2.
    assign accept = hsel && htrans[1] && hready && (state_q != S_ERR2);

    // Next-state selection; all outputs decode from registered state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d    = S_IDLE;
        pend_reg_d = accept ? is_reg : pend_reg_q;
        case (state_q)
            S_IDLE, S_WRITE, S_READ: begin
                if (accept) begin
                    if (xfer_err)
                        state_d = S_ERR1;
                    else if (!is_reg && bufBusy)
                        state_d = S_WAIT;
                    else
                        state_d = hwrite ? S_WRITE : S_READ;
                end
            end
            S_WAIT:  state_d = bufBusy ? S_WAIT : (pend_write_q ? S_WRITE : S_READ);
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // State, transfer attributes and the buffer-reserved flag.
    always_ff @(posedge clk or negedge nRst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!nRst) begin
            state_q      <= S_IDLE;
            pend_write_q <= 1'b0;
            pend_reg_q   <= 1'b0;
            accAddr      <= '0;
            dataSize     <= '0;
            reserved_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                accAddr      <= haddr;
                dataSize     <= hsize;
                pend_write_q <= hwrite;
                pend_reg_q   <= is_reg;
            end
            // Set in the store cycle itself and kept if a release coincides with it.
            reserved_q <= ((state_d == S_WRITE) && !pend_reg_d)
                        | storeTxData
                        | (reserved_q & ~bufRelease);
        end
    end

    // Output decode from the registered state.
    always_comb begin
        state          = state_q;
        storeTxData    = (state_q == S_WRITE) && !pend_reg_q;
        getRxData      = (state_q == S_READ)  && !pend_reg_q;
        regWrite       = (state_q == S_WRITE) &&  pend_reg_q;
        regRead        = (state_q == S_READ)  &&  pend_reg_q;
        hready         = (state_q != S_WAIT) && (state_q != S_ERR1);
        hresp          = (state_q == S_ERR1) || (state_q == S_ERR2);
        bufferReserved = reserved_q;
    end

endmodule

// File: tb/tb_ahb_slave_ctrl_p.sv
// tb_ahb_slave_ctrl_p: directed and randomized bench for ahb_slave_ctrl_p.
// A transaction-level model predicts every output each cycle; literal checks
// pin the model on the hand-worked scenarios.
module tb_ahb_slave_ctrl_p;

    localparam int ADDR_W    = 7;
    localparam int BUF_BYTES = 64;
    localparam int REG_COUNT = 9;
    localparam int RO_COUNT  = 8;
    localparam int MAX_SIZE  = 2;

    logic              clk = 1'b0;
    logic              nRst;
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [1:0]        hsize;
    logic              hwrite;
    logic              bufBusy;
    logic              bufRelease;
    logic [2:0]        state;
    logic              storeTxData, getRxData, regWrite, regRead;
    logic [ADDR_W-1:0] accAddr;
    logic [1:0]        dataSize;
    logic              hready, hresp, bufferReserved;

    always #5 clk = ~clk;

    ahb_slave_ctrl_p #(
        .ADDR_W(ADDR_W), .BUF_BYTES(BUF_BYTES), .REG_COUNT(REG_COUNT),
        .RO_COUNT(RO_COUNT), .MAX_SIZE(MAX_SIZE)
    ) dut (
        .clk(clk), .nRst(nRst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .bufBusy(bufBusy), .bufRelease(bufRelease),
        .state(state), .storeTxData(storeTxData), .getRxData(getRxData),
        .regWrite(regWrite), .regRead(regRead), .accAddr(accAddr),
        .dataSize(dataSize), .hready(hready), .hresp(hresp),
        .bufferReserved(bufferReserved)
    );

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // active: 0 none, 1 buffer write, 2 buffer read, 3 register write, 4 register read
    int m_err_left;
    bit m_wait, m_pw, m_res, m_last_ok;
    int m_active, m_addr, m_size;
    bit prev_store, bad, in_reg;

    function automatic bit illegal(int addr, int size, bit wr, int trans);
        int bytes = 1 << size;
        if (size > MAX_SIZE) return 1'b1;
        if (addr % bytes != 0) return 1'b1;
        if (addr < BUF_BYTES && addr + bytes > BUF_BYTES) return 1'b1;
        if (addr >= BUF_BYTES + REG_COUNT) return 1'b1;
        if (addr >= BUF_BYTES) begin
            if (wr && addr - BUF_BYTES < RO_COUNT) return 1'b1;
            if (size != 0) return 1'b1;
        end
`ifdef SEQ_CHECK_EN
        if (trans == 3 && (addr != m_addr + (1 << m_size) || size != m_size || !m_last_ok))
            return 1'b1;
`else
        if (trans < 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m_err_left = 0; m_wait = 0; m_pw = 0; m_res = 0; m_last_ok = 0;
            m_active = 0; m_addr = 0; m_size = 0;
        end else begin
            prev_store = (m_active == 1);
            m_active = 0;
            if (m_err_left > 0) begin
                m_err_left--;
            end else if (m_wait) begin
                if (!bufBusy) begin
                    m_wait   = 0;
                    m_active = m_pw ? 1 : 2;
                end
            end else if (hsel && htrans[1]) begin
                bad       = illegal(int'(haddr), int'(hsize), hwrite, int'(htrans));
                m_addr    = int'(haddr);
                m_size    = int'(hsize);
                m_last_ok = !bad;
                in_reg    = (m_addr >= BUF_BYTES) && (m_addr < BUF_BYTES + REG_COUNT);
                if (bad)          m_err_left = 2;
                else if (in_reg)  m_active = hwrite ? 3 : 4;
                else if (bufBusy) begin m_wait = 1; m_pw = hwrite; end
                else              m_active = hwrite ? 1 : 2;
            end else if (!hsel || htrans == 2'b00) begin
                m_last_ok = 0;
            end
            m_res = (m_active == 1) || (m_res && !(bufRelease && !prev_store));
        end
    end

    function automatic int exp_state();
        if (m_err_left == 2) return 4;
        if (m_err_left == 1) return 5;
        if (m_wait) return 3;
        if (m_active == 1 || m_active == 3) return 1;
        if (m_active == 2 || m_active == 4) return 2;
        return 0;
    endfunction

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (run_cmp && nRst === 1'b1) begin
            check("state",          32'(state),          32'(exp_state()));
            check("storeTxData",    32'(storeTxData),    32'(m_active == 1));
            check("getRxData",      32'(getRxData),      32'(m_active == 2));
            check("regWrite",       32'(regWrite),       32'(m_active == 3));
            check("regRead",        32'(regRead),        32'(m_active == 4));
            check("hready",         32'(hready),         32'(!(m_wait || m_err_left == 2)));
            check("hresp",          32'(hresp),          32'(m_err_left > 0));
            check("accAddr",        32'(accAddr),        32'(m_addr));
            check("dataSize",       32'(dataSize),       32'(m_size));
            check("bufferReserved", 32'(bufferReserved), 32'(m_res));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit s, input int a, input int tr, input int sz, input bit wr);
        hsel   = s;
        haddr  = ADDR_W'(a);
        htrans = 2'(tr);
        hsize  = 2'(sz);
        hwrite = wr;
    endtask

    task automatic set_idle();
        set_in(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic err_seq(input string tag, input int a, input int sz, input bit wr);
        set_in(1'b1, a, 2, sz, wr);
        step();
        set_idle();
        check({tag, " err1 state"}, 32'(state), 32'd4);
        check({tag, " err1 hready"}, 32'(hready), 32'd0);
        check({tag, " err1 hresp"}, 32'(hresp), 32'd1);
        check({tag, " err1 strobes"}, 32'({storeTxData, getRxData, regWrite, regRead}), 32'd0);
        step();
        check({tag, " err2 state"}, 32'(state), 32'd5);
        check({tag, " err2 hready/hresp"}, 32'({hready, hresp}), 32'd3);
        step();
        check({tag, " back to idle"}, 32'({state, hresp}), 32'd0);
    endtask

    int last_a;
    int a, sz;

    initial begin
        nRst = 1'b0; bufBusy = 1'b0; bufRelease = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #2;
        check("reset state", 32'(state), 32'd0);
        check("reset hready", 32'(hready), 32'd1);
        check("reset hresp", 32'(hresp), 32'd0);
        check("reset reserved", 32'(bufferReserved), 32'd0);
        check("reset strobes", 32'({storeTxData, getRxData, regWrite, regRead}), 32'd0);
        check("reset accAddr", 32'(accAddr), 32'd0);
        @(negedge clk); #2;
        nRst = 1'b1;
        run_cmp = 1'b1;
        step();

        // NONSEQ write to 0x00, then release the buffer.
        set_in(1'b1, 'h00, 2, 2, 1'b1);
        step();
        set_idle();
        check("wr0 state", 32'(state), 32'd1);
        check("wr0 store", 32'(storeTxData), 32'd1);
        check("wr0 dataSize", 32'(dataSize), 32'd2);
        check("wr0 reserved", 32'(bufferReserved), 32'd1);
        step();
        check("reserved holds", 32'(bufferReserved), 32'd1);
        bufRelease = 1'b1;
        step();
        bufRelease = 1'b0;
        check("reserved released", 32'(bufferReserved), 32'd0);

        // Back-to-back reads.
        set_in(1'b1, 'h20, 2, 2, 1'b0);
        step();
        check("rd20 getRx", 32'(getRxData), 32'd1);
        check("rd20 accAddr", 32'(accAddr), 32'h20);
        set_in(1'b1, 'h24, 2, 2, 1'b0);
        step();
        set_idle();
        check("rd24 getRx", 32'(getRxData), 32'd1);
        check("rd24 accAddr", 32'(accAddr), 32'h24);
        step();

        // Write 0x10 while the USB side holds the buffer.
        bufBusy = 1'b1;
        set_in(1'b1, 'h10, 2, 2, 1'b1);
        step();
        set_idle();
        check("wait1", 32'({state, hready}), 32'({3'd3, 1'b0}));
        step();
        check("wait2", 32'({state, hready}), 32'({3'd3, 1'b0}));
        step();
        check("wait3", 32'({state, hready, storeTxData}), 32'({3'd3, 1'b0, 1'b0}));
        bufBusy = 1'b0;
        step();
        check("wait exit store", 32'({state, storeTxData, hready}), 32'({3'd1, 1'b1, 1'b1}));
        step();

        // Register read never waits.
        bufBusy = 1'b1;
        set_in(1'b1, 'h41, 2, 0, 1'b0);
        step();
        set_idle();
        bufBusy = 1'b0;
        check("reg41 regRead", 32'(regRead), 32'd1);
        check("reg41 getRx", 32'(getRxData), 32'd0);
        step();

        // Error responses.
        err_seq("ro43", 'h43, 0, 1'b1);
        err_seq("size3", 'h15, 3, 1'b1);
        err_seq("mis3e", 'h3E, 2, 1'b1);
        err_seq("range", 'h50, 0, 1'b0);

        // SEQ continuation.
        set_in(1'b1, 'h00, 2, 2, 1'b1);
        step();
        set_in(1'b1, 'h04, 3, 2, 1'b1);
        step();
        check("seq04 legal", 32'({state, storeTxData}), 32'({3'd1, 1'b1}));
        set_in(1'b1, 'h0C, 3, 2, 1'b1);
        step();
        set_idle();
`ifdef SEQ_CHECK_EN
        check("seq0c error", 32'(state), 32'd4);
`else
        check("seq0c legal", 32'({state, storeTxData}), 32'({3'd1, 1'b1}));
`endif
        repeat (3) step();

        // Reset in the middle of a waited transfer aborts it.
        bufBusy = 1'b1;
        set_in(1'b1, 'h08, 2, 2, 1'b1);
        step();
        set_idle();
        check("pre-abort wait", 32'(state), 32'd3);
        #2 nRst = 1'b0;
        #1;
        check("abort state", 32'({state, hready, storeTxData}), 32'({3'd0, 1'b1, 1'b0}));
        bufBusy = 1'b0;
        @(negedge clk); #2;
        nRst = 1'b1;
        step();
        check("after abort idle", 32'({state, storeTxData}), 32'd0);

        // Randomized traffic.
        last_a = 0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 127);
                1:       a = $urandom_range(0, 15) * 4;
                2:       a = $urandom_range(60, 75);
                default: a = (last_a + 4) % 128;
            endcase
            sz = (a >= BUF_BYTES && $urandom_range(0, 3) != 0) ? 0 : $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) sz = 2;
            set_in($urandom_range(0, 9) < 8, a, $urandom_range(0, 3), sz, 1'($urandom_range(0, 1)));
            bufBusy    = ($urandom_range(0, 9) < 3);
            bufRelease = ($urandom_range(0, 9) == 0);
            last_a = a;
            step();
        end
        set_idle();
        bufBusy = 1'b0;
        bufRelease = 1'b0;
        repeat (4) step();
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
